// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// stage indices, scoreboard entry layout and a readiness helper.
package pipe_pkg;

  // Default register-address width (32 architectural registers).
  localparam int unsigned REG_AW = 5;

  // Post-ID stage indices as seen by the scoreboard.
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // Forwarding select value meaning "take the register-file read".
  localparam int unsigned FWD_RF = 0;

  // Scoreboard field widths; wide enough for any practical REG_AW/NSTAGE.
  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned SB_IDX_W = 4;

  // One in-flight register write.
  typedef struct packed {
    logic                v;    // entry holds a real register write
    logic [SB_RD_W-1:0]  rd;   // destination register
    logic [SB_IDX_W-1:0] rdy;  // stage index whose pipeline register holds the result
  } sb_entry_t;

  // A producer at stage s satisfies a consumer when its result is (or will be,
  // by the time a normal consumer reaches EX) sitting in a pipeline register.
  function automatic logic src_ready(input int unsigned s,
                                     input int unsigned rdy,
                                     input logic        early);
    if (early) return (s >= rdy);
    return ((s + 1) >= rdy);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match search of the write scoreboard for one source register.
// Entries below LO are excluded from the search.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SELW   = 2,
  parameter int unsigned LO     = 0
) (
  input  sb_entry_t [NSTAGE-1:0] sb_i,
  input  logic [REG_AW-1:0]      r_i,
  input  logic                   used_i,
  output logic                   hit_o,
  output logic [SELW-1:0]        idx_o,
  output logic [SB_IDX_W-1:0]    rdy_o
);

  logic [SB_RD_W-1:0] r_ext;

  assign r_ext = SB_RD_W'(r_i);

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    rdy_o = '0;
    for (int unsigned k = NSTAGE; k > LO; k--) begin
      if (sb_i[k-1].v && (sb_i[k-1].rd == r_ext) && (r_ext != '0) && used_i) begin
        hit_o = 1'b1;
        idx_o = SELW'(k - 1);
        rdy_o = sb_i[k-1].rdy;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order pipeline. A scoreboard of
// in-flight register writes drives the PC/IF_ID stall, the ID_EX bubble, the
// IF flush, and the forwarding selects for the ID branch comparator and the
// EX ALU operands.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW   = pipe_pkg::REG_AW,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned LOAD_RDY = STG_WB,
  parameter int unsigned ALU_RDY  = STG_MEM,
  parameter int unsigned SELW     = $clog2(NSTAGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_early,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              if_flush,
  output logic [SELW-1:0]   fwd_a_id,
  output logic [SELW-1:0]   fwd_b_id,
  output logic [SELW-1:0]   fwd_a_ex,
  output logic [SELW-1:0]   fwd_b_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  sb_entry_t [NSTAGE-1:0] sb_q, sb_d;

  logic [REG_AW-1:0] ex_rs_q, ex_rt_q;
  logic              ex_rs_used_q, ex_rt_used_q;

  logic                hit_a_id, hit_b_id, hit_a_ex, hit_b_ex;
  logic [SELW-1:0]     idx_a_id, idx_b_id, idx_a_ex, idx_b_ex;
  logic [SB_IDX_W-1:0] rdy_a_id, rdy_b_id, rdy_a_ex, rdy_b_ex;

  logic            haz_a, haz_b;
  logic            stall_raw, flush_raw, id_adv;
  logic [SELW-1:0] fwd_a_id_raw, fwd_b_id_raw, fwd_a_ex_raw, fwd_b_ex_raw;

  // ID-stage consumers search the whole scoreboard.
  hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SELW(SELW), .LO(STG_EX)) u_match_a_id (
    .sb_i(sb_q), .r_i(id_rs), .used_i(id_rs_used),
    .hit_o(hit_a_id), .idx_o(idx_a_id), .rdy_o(rdy_a_id)
  );

  hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SELW(SELW), .LO(STG_EX)) u_match_b_id (
    .sb_i(sb_q), .r_i(id_rt), .used_i(id_rt_used),
    .hit_o(hit_b_id), .idx_o(idx_b_id), .rdy_o(rdy_b_id)
  );

  // EX-stage consumers skip entry 0, which is the EX instruction itself.
  hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SELW(SELW), .LO(STG_MEM)) u_match_a_ex (
    .sb_i(sb_q), .r_i(ex_rs_q), .used_i(ex_rs_used_q),
    .hit_o(hit_a_ex), .idx_o(idx_a_ex), .rdy_o(rdy_a_ex)
  );

  hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SELW(SELW), .LO(STG_MEM)) u_match_b_ex (
    .sb_i(sb_q), .r_i(ex_rt_q), .used_i(ex_rt_used_q),
    .hit_o(hit_b_ex), .idx_o(idx_b_ex), .rdy_o(rdy_b_ex)
  );

  // Hazard detection and forwarding selects for both consumers.
  always_comb begin
    haz_a = hit_a_id && !src_ready(32'(idx_a_id), 32'(rdy_a_id), id_early);
    haz_b = hit_b_id && !src_ready(32'(idx_b_id), 32'(rdy_b_id), id_early);

    stall_raw = id_valid & (haz_a | haz_b);
    flush_raw = br_taken & ~stall_raw;
    id_adv    = id_valid & ~stall_raw;

    fwd_a_id_raw = SELW'(FWD_RF);
    if (hit_a_id && (32'(idx_a_id) >= 1) && (32'(idx_a_id) >= 32'(rdy_a_id)))
      fwd_a_id_raw = idx_a_id;

    fwd_b_id_raw = SELW'(FWD_RF);
    if (hit_b_id && (32'(idx_b_id) >= 1) && (32'(idx_b_id) >= 32'(rdy_b_id)))
      fwd_b_id_raw = idx_b_id;

    // The stall rules already guarantee readiness here; the check is a guard.
    fwd_a_ex_raw = SELW'(FWD_RF);
    if (hit_a_ex && (32'(idx_a_ex) >= 32'(rdy_a_ex)))
      fwd_a_ex_raw = idx_a_ex;

    fwd_b_ex_raw = SELW'(FWD_RF);
    if (hit_b_ex && (32'(idx_b_ex) >= 32'(rdy_b_ex)))
      fwd_b_ex_raw = idx_b_ex;
  end

  // Outputs are forced low while reset is asserted (br_taken may be high then).
  assign stall    = rst & stall_raw;
  assign bubble   = rst & stall_raw;
  assign if_flush = rst & flush_raw;
  assign fwd_a_id = rst ? fwd_a_id_raw : '0;
  assign fwd_b_id = rst ? fwd_b_id_raw : '0;
  assign fwd_a_ex = rst ? fwd_a_ex_raw : '0;
  assign fwd_b_ex = rst ? fwd_b_ex_raw : '0;

  // Next scoreboard: new entry (or bubble) at EX, everything else shifts down.
  always_comb begin
    sb_d = '0;
    if (id_adv && id_wr && (id_rd != '0)) begin
      sb_d[STG_EX].v   = 1'b1;
      sb_d[STG_EX].rd  = SB_RD_W'(id_rd);
      sb_d[STG_EX].rdy = SB_IDX_W'(id_is_load ? LOAD_RDY : ALU_RDY);
    end
    for (int unsigned k = 1; k < NSTAGE; k++)
      sb_d[k] = sb_q[k-1];
  end

  // Scoreboard and EX source-register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q         <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rs_used_q <= 1'b0;
      ex_rt_used_q <= 1'b0;
    end else begin
      sb_q         <= sb_d;
      ex_rs_q      <= id_adv ? id_rs : '0;
      ex_rt_q      <= id_adv ? id_rt : '0;
      ex_rs_used_q <= id_adv & id_rs_used;
      ex_rt_used_q <= id_adv & id_rt_used;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of stalled and flushing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_raw && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_raw && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed testbench for pipe_hazard_unit with default parameters.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_early, id_wr, id_is_load, br_taken;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, bubble, if_flush;
  logic [1:0] fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int unsigned vec  = 0;
  int unsigned errs = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .REG_AW(5), .NSTAGE(3), .LOAD_RDY(2), .ALU_RDY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_early(id_early), .id_wr(id_wr), .id_rd(id_rd),
    .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall), .bubble(bubble), .if_flush(if_flush),
    .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic early,
                       input logic wr, input logic [4:0] rd, input logic ld,
                       input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_early = early; id_wr = wr; id_rd = rd; id_is_load = ld; br_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    #3;
    vec++; if ({stall, bubble, if_flush} !== 3'b000) begin errs++;
      $display("FAIL reset_ctl: got %b want 000", {stall, bubble, if_flush}); end
    vec++; if ({fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex} !== 8'h00) begin errs++;
      $display("FAIL reset_fwd: got %h want 00", {fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex}); end
    tick();
    rst = 1'b1;
    idle();
    sample();
    vec++; if (stall !== 1'b0) begin errs++;
      $display("FAIL reset_release_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_alu_alu();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0); // add $3,$1,$2
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL alu_alu_c1_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0); // sub $4,$3,$5
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL alu_alu_c2_stall: got %b want 0", stall); end
    vec++; if (fwd_a_id !== 2'd0) begin errs++; $display("FAIL alu_alu_c2_fwd_a_id: got %0d want 0", fwd_a_id); end
    tick();
    idle();
    sample();
    vec++; if (fwd_a_ex !== 2'd1) begin errs++; $display("FAIL alu_alu_fwd_a_ex: got %0d want 1", fwd_a_ex); end
    vec++; if (fwd_b_ex !== 2'd0) begin errs++; $display("FAIL alu_alu_fwd_b_ex: got %0d want 0", fwd_b_ex); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); // lw $3,0($0)
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL load_use_c1_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0); // add $4,$3,$3
    sample();
    vec++; if ({stall, bubble} !== 2'b11) begin errs++; $display("FAIL load_use_c2_stall_bubble: got %b want 11", {stall, bubble}); end
    tick();
    sample();
    vec++; if ({stall, bubble} !== 2'b00) begin errs++; $display("FAIL load_use_c3_stall_bubble: got %b want 00", {stall, bubble}); end
    vec++; if (fwd_a_id !== 2'd0) begin errs++; $display("FAIL load_use_c3_fwd_a_id: got %0d want 0", fwd_a_id); end
    tick();
    idle();
    sample();
    vec++; if (fwd_a_ex !== 2'd2) begin errs++; $display("FAIL load_use_fwd_a_ex: got %0d want 2", fwd_a_ex); end
    vec++; if (fwd_b_ex !== 2'd2) begin errs++; $display("FAIL load_use_fwd_b_ex: got %0d want 2", fwd_b_ex); end
    tick();
    drain();
  endtask

  task automatic test_alu_branch();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0); // add $3,$1,$2
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); // beq $3,$0 taken
    sample();
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL alu_br_c2_stall: got %b want 1", stall); end
    vec++; if (if_flush !== 1'b0) begin errs++; $display("FAIL alu_br_c2_flush: got %b want 0", if_flush); end
    tick();
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL alu_br_c3_stall: got %b want 0", stall); end
    vec++; if ({fwd_a_id, fwd_b_id} !== 4'b0100) begin errs++; $display("FAIL alu_br_c3_fwd_id: got %b want 0100", {fwd_a_id, fwd_b_id}); end
    vec++; if (if_flush !== 1'b1) begin errs++; $display("FAIL alu_br_c3_flush: got %b want 1", if_flush); end
    tick();
    idle();
    sample();
    vec++; if (if_flush !== 1'b0) begin errs++; $display("FAIL alu_br_c4_flush: got %b want 0", if_flush); end
    tick();
    drain();
  endtask

  task automatic test_load_branch();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); // lw $3
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); // beq $3,$3
    sample();
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL ld_br_c2_stall: got %b want 1", stall); end
    tick();
    sample();
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL ld_br_c3_stall: got %b want 1", stall); end
    tick();
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL ld_br_c4_stall: got %b want 0", stall); end
    vec++; if (fwd_a_id !== 2'd2) begin errs++; $display("FAIL ld_br_c4_fwd_a_id: got %0d want 2", fwd_a_id); end
    vec++; if (fwd_b_id !== 2'd2) begin errs++; $display("FAIL ld_br_c4_fwd_b_id: got %0d want 2", fwd_b_id); end
    tick();
    drain();
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); // add $0,$1,$2
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0); // lw $0
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); // beq $0,$0
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL zero_br_stall: got %b want 0", stall); end
    vec++; if ({fwd_a_id, fwd_b_id} !== 4'b0000) begin errs++; $display("FAIL zero_br_fwd_id: got %b want 0000", {fwd_a_id, fwd_b_id}); end
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0); // add $5,$0,$0
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL zero_add_stall: got %b want 0", stall); end
    tick();
    idle();
    sample();
    vec++; if ({fwd_a_ex, fwd_b_ex} !== 4'b0000) begin errs++; $display("FAIL zero_fwd_ex: got %b want 0000", {fwd_a_ex, fwd_b_ex}); end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0); // add $7,$1,$2
    tick();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0); // add $7,$3,$4
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0); // add $8,$7,$7
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL young_c3_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); // beq $7,$7
    sample();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL young_c4_stall: got %b want 0", stall); end
    vec++; if ({fwd_a_id, fwd_b_id} !== 4'b0101) begin errs++; $display("FAIL young_fwd_id: got %b want 0101", {fwd_a_id, fwd_b_id}); end
    vec++; if ({fwd_a_ex, fwd_b_ex} !== 4'b0101) begin errs++; $display("FAIL young_fwd_ex: got %b want 0101", {fwd_a_ex, fwd_b_ex}); end
    tick();
    drain();
  endtask

  task automatic test_reset_midstall();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); // lw $3
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1); // add $4,$3,$3 with br_taken
    sample();
    vec++; if ({stall, if_flush} !== 2'b10) begin errs++; $display("FAIL midrst_pre: got %b want 10", {stall, if_flush}); end
    rst = 1'b0;
    #1;
    vec++; if ({stall, bubble, if_flush} !== 3'b000) begin errs++; $display("FAIL midrst_ctl: got %b want 000", {stall, bubble, if_flush}); end
    vec++; if ({fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex} !== 8'h00) begin errs++;
      $display("FAIL midrst_fwd: got %h want 00", {fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex}); end
    tick();
    sample();
    vec++; if ({stall, bubble, if_flush} !== 3'b000) begin errs++; $display("FAIL midrst_held: got %b want 000", {stall, bubble, if_flush}); end
    tick();
    rst = 1'b1;
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    sample();
    vec++; if ({stall, bubble} !== 2'b00) begin errs++; $display("FAIL midrst_after_stall: got %b want 00", {stall, bubble}); end
`ifdef HAZARD_PERF_CNT_EN
    vec++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
    vec++; if (flush_cnt !== 32'd0) begin errs++; $display("FAIL midrst_flush_cnt: got %0d want 0", flush_cnt); end
`endif
    tick();
    drain();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_alu();
    test_load_use();
    test_alu_branch();
    test_load_branch();
    test_reg_zero();
    test_youngest();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
